// File: rtl/seq_mult_if.sv
// Operand/result bundle for seq_mult_unit.
// master: issues start + operands, watches busy/done/product. slave: the unit.
interface seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier, signed/unsigned, WIDTH+1 cycle latency.
// Ports: clk, rst (sync, active high), bus (seq_mult_if.slave: start/operands in, busy/done/product out).
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    seq_mult_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic              neg_q, neg_d;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH:0]    sum;

    // Magnitudes: -2^(W-1) negates to itself, which reads correctly as unsigned.
    always_comb begin
        mag_a = bus.multiplicand;
        mag_b = bus.multiplier;
        if (bus.signed_mode && bus.multiplicand[WIDTH-1])
            mag_a = ~bus.multiplicand + WIDTH'(1);
        if (bus.signed_mode && bus.multiplier[WIDTH-1])
            mag_b = ~bus.multiplier + WIDTH'(1);
    end

    // Upper half gets the partial sum with carry; lower half holds the
    // shrinking multiplier, so acc_q[0] is the current multiplier bit.
    always_comb begin
        sum = {1'b0, acc_q[PW-1:WIDTH]};
        if (acc_q[0])
            sum = sum + {1'b0, mcand_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    mcand_d = mag_a;
                    neg_d   = bus.signed_mode &
                              (bus.multiplicand[WIDTH-1] ^
                               bus.multiplier[WIDTH-1]);
                end
            end
            S_CALC: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                prod_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.busy    = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = prod_q;
endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
Parametrised sequential shift-add multiplier: control FSM, iteration counter and datapath in one block. Successor to the fixed 32-bit unsigned multiplier control. Adds a WIDTH parameter, a signed/unsigned mode selected per operation, and a start/busy/done handshake. Sits beside the ALU; the result is held until the next accepted operation.

Parameters:
WIDTH, 32, operand width in bits (legal range 2..64); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
multiplicand  input  WIDTH  operand A; captured with start
multiplier  input  WIDTH  operand B; captured with start
busy  output  1  high in CALC and FIX
done  output  1  high in DONE; product valid
product  output  2*WIDTH  registered result

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything else.
  - state=IDLE; busy=0; done=0; product=0; counter=0; internal registers=0.
  - Applies from any state, including mid-CALC; the aborted operation leaves no result.
- States:
  - IDLE: start=1 → CALC.
  - CALC: counter reaches WIDTH-1 → FIX.
  - FIX: → DONE unconditionally.
  - DONE: start=1 → CALC; otherwise stay in DONE.
- Capture (edge where start is accepted):
  - Latch signed_mode.
  - Latch neg_flag = signed_mode & (A[MSB] ^ B[MSB]).
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes. In unsigned mode the magnitude is the operand unchanged.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits in WIDTH unsigned bits, so there is no overflow.
  - Clear the accumulator, set counter=0, done→0.
- CALC, one iteration per edge:
  - If multiplier-magnitude LSB=1, add multiplicand magnitude to the upper half of the 2*WIDTH accumulator, keeping the carry (WIDTH+1-bit add).
  - Shift {carry, accumulator} right by 1; the multiplier magnitude occupies the lower half and shifts out.
  - Exactly WIDTH iterations.
  - Fixed latency: no early exit on zero operands.
- FIX:
  - product ← neg_flag ? (~acc + 1) : acc, computed mod 2^(2*WIDTH).
  - product is written only on this edge and holds its value in every other state.
- Latency: done is first high after WIDTH+1 rising edges following the edge that accepts start (WIDTH=8 → 9 edges). busy is high for exactly WIDTH+1 cycles.
- start while busy: ignored, with no queuing. Operand input changes while busy have no effect.
- start in DONE (back-to-back):
  - Accepted on that edge; done falls the next cycle.
  - product keeps the old result until the new FIX edge.
- Result range:
  - Signed mode: the full 2*WIDTH result is exact, including (-2^(W-1))² = 2^(2W-2).
  - Unsigned mode: max (2^W-1)² is exact.
- busy and done are never high simultaneously.

Test Plan:
- WIDTH=8, unsigned, 255×255, start one cycle → done after 9 edges, product=16'hFE01, busy high for 9 cycles.
- WIDTH=8, signed, 8'h80×8'h80 (-128×-128) → product=16'h4000. Same operands in unsigned mode → 16'h4000 (128×128).
- WIDTH=8, signed, 8'hFD×8'h05 (-3×5) → 16'hFFF1. Unsigned 8'hFD×8'h05 → 16'h04F1 (1265).
- WIDTH=8: start 7×6; 3 cycles later pulse start with 9×9 and change operands → ignored, product=16'h002A. Then start again in DONE with 9×9 → done drops for 9 cycles, product stays 16'h002A until the FIX edge, then becomes 16'h0051.
- Reset mid-CALC (rst at edge 4 of an operation) → next cycle busy=0, done=0, product=0, IDLE. A new start then completes normally in 9 edges.
- WIDTH=32 default, signed, 32'h80000000×32'h7FFFFFFF → 64'hC000000080000000. Also 0×anything → 0 with full 33-edge latency.
